instr_sequencer: RTL and testbench

- Multi-cycle phase controller for the single-issue datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, selecting phases by the 5-bit opcode class.
- Gates the register-file write, PC update and data-memory strobes to the correct phase.
- Adds a data-memory ready handshake with timeout, a retired-instruction counter and sticky error flags.
- Sits between the instruction register/PC and the combinational decode: decode still drives mux selects; this block owns only when things happen.

---
 rtl/instr_sequencer.sv | 141 ++++++++++++++
 tb/tb_instr_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle phase controller: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// by opcode class and decides when the datapath strobes fire.
module instr_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8,
  parameter int TO_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             branch_taken,
  input  logic             dm_ready,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_write,
  output logic             dm_req,
  output logic             dm_we,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             mem_err,
  output logic             illegal_op,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ALU = 3'd0,
    C_BR  = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_NOP = 3'd4
  } cls_t;

  localparam logic [TO_W-1:0] TIMEOUT_V  = TO_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t          state;
  cls_t            cls;
  cls_t            dec_cls;
  logic            dec_legal;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_inc;
  logic            timeout_hit;
  logic            exec_retire;
  logic            mem_retire;
  logic            retire;

  // Unknown opcodes run with NOP timing; only the sticky flag records them.
  always_comb begin
    dec_cls   = C_NOP;
    dec_legal = 1'b1;
    case (opcode)
      5'b00010, 5'b00001, 5'b01011, 5'b01000: dec_cls = C_ALU;
      5'b00011, 5'b00100:                     dec_cls = C_BR;
      5'b00000:                               dec_cls = C_LD;
      5'b01100:                               dec_cls = C_ST;
      5'b00111:                               dec_cls = C_NOP;
      default:                                dec_legal = 1'b0;
    endcase
  end

  assign wait_inc    = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (state == S_MEM) && !dm_ready && (wait_inc == TIMEOUT_V);
  assign exec_retire = (state == S_EXEC) && ((cls == C_BR) || (cls == C_NOP));
  assign mem_retire  = (state == S_MEM) && ((dm_ready && (cls == C_ST)) || timeout_hit);
  assign retire      = exec_retire || mem_retire || (state == S_WB);

  // Strobes are decodes of the registered phase; run, branch_taken and dm_ready
  // only qualify them in the one phase where each is meaningful.
  assign phase      = state;
  assign ir_load    = (state == S_FETCH) && run && !RST;
  assign pc_load    = exec_retire && (cls == C_BR) && branch_taken;
  assign pc_inc     = retire && !pc_load;
  assign instr_done = retire;
  assign reg_write  = (state == S_WB);
  assign dm_req     = (state == S_MEM);
  assign dm_we      = dm_req && (cls == C_ST);
  assign busy       = (state != S_FETCH) || ir_load;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_FETCH;
      cls        <= C_NOP;
      wait_cnt   <= '0;
      retired    <= '0;
      mem_err    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run) state <= S_DECODE;
        end
        S_DECODE: begin
          cls   <= dec_cls;
          state <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (cls)
            C_ALU:       state <= S_WB;
            C_LD, C_ST:  state <= S_MEM;
            default:     state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dm_ready) begin
            state <= (cls == C_LD) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state <= S_FETCH;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase

      if (retire) retired <= retired + 1'b1;

      // A set event in the same cycle as err_clr keeps the flag set.
      illegal_op <= ((state == S_DECODE) && !dec_legal) || (illegal_op && !err_clr);
      mem_err    <= timeout_hit || (mem_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: the driver predicts each instruction's
// timing from the opcode-class rules, and a monitor checks every retire against it.
module tb_instr_sequencer;
  localparam int CNT_W = 4;
  localparam int TMO   = 8;
  localparam int TO_W  = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             run;
  logic [4:0]       opcode;
  logic             branch_taken;
  logic             dm_ready;
  logic             err_clr;
  logic [2:0]       phase;
  logic             ir_load, pc_inc, pc_load, reg_write, dm_req, dm_we, instr_done;
  logic [CNT_W-1:0] retired;
  logic             mem_err, illegal_op, busy;

  always #5 CLK = ~CLK;

  instr_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO), .TO_W(TO_W)) dut (
    .CLK(CLK), .RST(RST), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .dm_ready(dm_ready), .err_clr(err_clr), .phase(phase), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write), .dm_req(dm_req),
    .dm_we(dm_we), .instr_done(instr_done), .retired(retired), .mem_err(mem_err),
    .illegal_op(illegal_op), .busy(busy)
  );

  typedef struct {
    logic [4:0]  op;
    int          lat;
    logic [47:0] sig;
    int          rw;
    int          dq;
    int          dw;
    int          pcl;
    int          il;
    int          me;
    int          ret;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_ret = 0;
  int   m_il  = 0;
  int   m_me  = 0;
  logic [4:0] legal_ops [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 ALU, 1 BR, 2 LD, 3 ST, 4 NOP, 5 illegal
  function automatic int op_class(input logic [4:0] op);
    case (op)
      5'b00010, 5'b00001, 5'b01011, 5'b01000: return 0;
      5'b00011, 5'b00100:                     return 1;
      5'b00000:                               return 2;
      5'b01100:                               return 3;
      5'b00111:                               return 4;
      default:                                return 5;
    endcase
  endfunction

  // Predict, enqueue, then drive one instruction starting in a FETCH cycle.
  task automatic do_instr(input logic [4:0] op, input logic bt, input int w,
                          input int clr, input int idle);
    exp_t e;
    int   c, memc, lat;
    bit   memcls, abort;
    c      = op_class(op);
    memcls = (c == 2) || (c == 3);
    abort  = memcls && (w >= TMO);
    memc   = memcls ? (abort ? TMO : w + 1) : 0;
    case (c)
      0:       lat = 4;
      2:       lat = abort ? 3 + memc : 4 + memc;
      3:       lat = 3 + memc;
      default: lat = 3;
    endcase
    e.op  = op;
    e.lat = lat;
    e.sig = '0;
    for (int k = 1; k <= lat; k++) begin
      int ph;
      if (k <= 3) ph = k - 1;
      else if (memcls && k <= 3 + memc) ph = 3;
      else ph = 4;
      e.sig[3*(k-1) +: 3] = 3'(ph);
    end
    e.rw  = (c == 0 || (c == 2 && !abort)) ? 1 : 0;
    e.dq  = memc;
    e.dw  = (c == 3) ? memc : 0;
    e.pcl = (c == 1 && bt) ? 1 : 0;
    for (int k = 1; k <= lat; k++) begin
      if (k == clr) begin m_il = 0; m_me = 0; end
      if (k == 2 && c == 5) m_il = 1;
      if (k == lat && abort) m_me = 1;
    end
    e.il  = m_il;
    e.me  = m_me;
    m_ret = (m_ret + 1) % (1 << CNT_W);
    e.ret = m_ret;
    sb.push_back(e);

    for (int k = 1; k <= lat; k++) begin
      run          = (k == 1) ? 1'b1 : 1'($urandom);
      opcode       = (k == 2) ? op : 5'($urandom);
      branch_taken = (k == 3) ? bt : 1'($urandom);
      dm_ready     = (memcls && k >= 4 && k <= 3 + memc) ? (k - 4 == w) : 1'($urandom);
      err_clr      = (k == clr);
      @(posedge CLK); #1;
    end
    for (int k = 0; k < idle; k++) begin
      run          = 1'b0;
      opcode       = 5'($urandom);
      branch_taken = 1'($urandom);
      dm_ready     = 1'($urandom);
      err_clr      = 1'b0;
      @(posedge CLK); #1;
    end
    run = 1'b0;
    err_clr = 1'b0;
  endtask

  // Monitor: accumulates per-instruction observations and checks each retire.
  bit          mon_track = 0;
  bit          mon_post  = 0;
  int          mon_cyc, mon_rw, mon_dq, mon_dw, mon_pcs, mon_bz, mon_idx;
  logic [47:0] mon_sig;
  exp_t        mon_e;

  initial begin
    mon_idx = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_track = 0;
        mon_post  = 0;
      end else begin
        if (mon_post) begin
          chk("retired", retired, mon_e.ret);
          chk("illegal_op", illegal_op, mon_e.il);
          chk("mem_err", mem_err, mon_e.me);
          mon_post = 0;
        end
        if (!mon_track && ir_load) begin
          mon_track = 1; mon_cyc = 0; mon_sig = '0;
          mon_rw = 0; mon_dq = 0; mon_dw = 0; mon_pcs = 0; mon_bz = 0;
        end
        if (mon_track) begin
          if (mon_cyc < 16) mon_sig[3*mon_cyc +: 3] = phase;
          mon_cyc++;
          mon_rw  += int'(reg_write);
          mon_dq  += int'(dm_req);
          mon_dw  += int'(dm_req && dm_we);
          mon_pcs += int'(pc_inc || pc_load);
          mon_bz  += int'(busy);
          if (instr_done) begin
            mon_track = 0;
            if (sb.size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL unexpected_retire: got retire with empty scoreboard expected none (t=%0t)", $time);
            end else begin
              mon_e = sb.pop_front();
              mon_idx++;
              chk("latency", mon_cyc, mon_e.lat);
              chk("phase_seq", mon_sig, mon_e.sig);
              chk("reg_write_cycles", mon_rw, mon_e.rw);
              chk("dm_req_cycles", mon_dq, mon_e.dq);
              chk("dm_we_cycles", mon_dw, mon_e.dw);
              chk("pc_load", pc_load, mon_e.pcl);
              chk("pc_strobes", mon_pcs, 1);
              chk("busy_cycles", mon_bz, mon_e.lat);
              $display("instr %0d op=%05b lat=%0d reg_write=%0d dm_req=%0d pc_load=%0b",
                       mon_idx, mon_e.op, mon_cyc, mon_rw, mon_dq, pc_load);
              mon_post = 1;
            end
          end else if (mon_cyc >= 40) begin
            mon_track = 0;
            n_vec++; n_bad++;
            $display("FAIL retire_timeout: got no retire in %0d cycles expected one (t=%0t)", mon_cyc, $time);
          end
        end else begin
          chk("idle_phase", phase, 0);
          chk("idle_strobes", {reg_write, dm_req, pc_inc, pc_load, instr_done, busy}, 0);
        end
      end
    end
  end

  initial begin
    legal_ops[0] = 5'b00010; legal_ops[1] = 5'b00001; legal_ops[2] = 5'b01011;
    legal_ops[3] = 5'b01000; legal_ops[4] = 5'b00011; legal_ops[5] = 5'b00100;
    legal_ops[6] = 5'b00000; legal_ops[7] = 5'b01100; legal_ops[8] = 5'b00111;
    RST = 1'b1; run = 1'b1; opcode = 5'b00010; branch_taken = 1'b1;
    dm_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_phase", phase, 0);
    chk("reset_strobes", {ir_load, pc_inc, pc_load, reg_write, dm_req, dm_we, instr_done, busy}, 0);
    chk("reset_retired", retired, 0);
    chk("reset_flags", {mem_err, illegal_op}, 0);
    @(posedge CLK); #1;
    run = 1'b0;
    RST = 1'b0;

    do_instr(5'b00010, 1'b1, 0, 0, 1);   // ALU
    do_instr(5'b00011, 1'b1, 0, 0, 0);   // branch taken
    do_instr(5'b00011, 1'b0, 0, 0, 1);   // branch not taken
    do_instr(5'b00000, 1'b0, 2, 0, 0);   // load, two wait cycles
    do_instr(5'b01100, 1'b0, 0, 0, 0);   // store, no wait
    do_instr(5'b00000, 1'b0, 30, 0, 1);  // load, memory never answers
    do_instr(5'b00111, 1'b0, 0, 1, 0);   // NOP with err_clr
    do_instr(5'b11111, 1'b0, 0, 0, 0);   // illegal
    do_instr(5'b10101, 1'b0, 0, 2, 0);   // illegal with err_clr in the same cycle
    do_instr(5'b01100, 1'b0, 12, 3 + TMO, 0); // store abort with err_clr on the abort cycle

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      int w, clr;
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 8)];
      else op = 5'($urandom);
      w   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 7));
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_instr(op, 1'($urandom), w, clr, int'($urandom_range(0, 2)));
    end

    for (int k = 0; k < 60 && (sb.size() != 0 || mon_post); k++) @(posedge CLK);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    // Reset while a store is stalled in MEM.
    run = 1'b1; opcode = 5'($urandom); dm_ready = 1'b0; err_clr = 1'b0;
    @(posedge CLK); #1;
    run = 1'b0; opcode = 5'b01100;
    @(posedge CLK); #1;
    opcode = 5'($urandom);
    @(posedge CLK); #1;
    chk("pre_reset_phase", phase, 3);
    chk("pre_reset_dm_req", dm_req, 1);
    #2 RST = 1'b1;
    #1;
    chk("mid_reset_phase", phase, 0);
    chk("mid_reset_strobes", {dm_req, dm_we, instr_done, pc_inc, pc_load, reg_write, ir_load}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("post_reset_phase", phase, 0);
      chk("post_reset_strobes", {ir_load, dm_req, pc_inc, pc_load, reg_write, instr_done}, 0);
      chk("post_reset_retired", retired, m_ret);
      chk("post_reset_flags", {mem_err, illegal_op}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
